// File: rtl/output_buffer_pkg.sv
// Shared types for the output stream buffer: FIFO entry layout, controller states, tag width.
package output_buffer_pkg;

    localparam int TAG_WIDTH       = 32;
    localparam int OBUF_DATA_WIDTH = 32;

    typedef struct packed {
        logic [OBUF_DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]       x;
        logic [TAG_WIDTH-1:0]       y;
        logic [TAG_WIDTH-1:0]       ch;
    } out_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } obuf_state_t;

endpackage

// File: rtl/out_fifo.sv
// Synchronous FIFO of output entries; head is read combinationally from registered storage,
// so a push is visible one cycle later and there is no empty-FIFO bypass.
module out_fifo
    import output_buffer_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = out_entry_t
) (
    input  logic   clk,
    input  logic   arst_in,
    input  logic   flush,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int               AW         = $clog2(DEPTH);
    localparam logic [AW:0]      CNT_ZERO   = {(AW+1){1'b0}};
    localparam logic [AW:0]      CNT_ONE    = (AW+1)'(1);
    localparam logic [AW:0]      CNT_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]    PTR_ZERO   = {AW{1'b0}};
    localparam logic [AW-1:0]    PTR_ONE    = AW'(1);
    localparam entry_t           ENTRY_ZERO = entry_t'({$bits(entry_t){1'b0}});

    entry_t          mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic            do_push_s;
    logic            do_pop_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == CNT_ZERO);
    assign head      = mem_r[rd_ptr_r];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts that push.
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Entry storage; cleared on reset so the head reads zero before the first push.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= ENTRY_ZERO;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else if (flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/output_stream_buffer.sv
// Captures finished output pixels into a FIFO and streams them to the host with valid/ready.
// Build option OUTPUT_BUFFER_RELU_EN clamps negative values to zero before they are stored.
module output_stream_buffer
    import output_buffer_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int FIFO_DEPTH         = 8,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64
) (
    input  logic                  clk,
    input  logic                  arst_in,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [31:0]           in_x,
    input  logic [31:0]           in_y,
    input  logic [31:0]           in_ch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [31:0]           out_x,
    output logic [31:0]           out_y,
    output logic [31:0]           out_ch,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [31:0]           received_count
);

    localparam logic [31:0] EXPECTED =
        32'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  x;
        logic [TAG_WIDTH-1:0]  y;
        logic [TAG_WIDTH-1:0]  ch;
    } entry_t;

    obuf_state_t            state_r;
    obuf_state_t            state_next_s;
    logic [31:0]            received_count_r;
    logic [31:0]            sent_count_r;
    logic [31:0]            dropped_count_r;
    logic                   overflow_r;
    logic                   busy_s;
    logic                   out_valid_s;
    logic                   accept_s;
    logic                   pop_s;
    logic                   drop_s;
    logic                   push_s;
    logic                   flush_s;
    logic                   last_in_s;
    logic                   final_pop_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [DATA_WIDTH-1:0]  push_data_s;
    entry_t                 push_entry_s;
    entry_t                 head_s;

    assign flush_s     = (state_r == IDLE) && start;
    assign accept_s    = (state_r == COLLECT) && in_valid;
    assign pop_s       = out_valid_s && out_ready;
    assign drop_s      = accept_s && fifo_full_s && !pop_s;
    assign push_s      = accept_s && !drop_s;
    assign last_in_s   = accept_s && (received_count_r == EXPECTED - 32'd1);
    // Dropped pixels count toward completion, so the layer ends on the handshake that
    // accounts for the last produced pixel.
    assign final_pop_s = (state_r == DRAIN) && pop_s &&
                         (sent_count_r + dropped_count_r + 32'd1 == EXPECTED);

    // Optional ReLU clamp on the value only; tags pass through unchanged.
    always_comb begin
        push_data_s = in_data;
`ifdef OUTPUT_BUFFER_RELU_EN
        if (in_data[DATA_WIDTH-1]) begin
            push_data_s = {DATA_WIDTH{1'b0}};
        end else begin
            push_data_s = in_data;
        end
`endif
    end

    assign push_entry_s = '{data: push_data_s, x: in_x, y: in_y, ch: in_ch};

    out_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_out_fifo (
        .clk     (clk),
        .arst_in (arst_in),
        .flush   (flush_s),
        .push    (push_s),
        .pop     (pop_s),
        .din     (push_entry_s),
        .head    (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // State register.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = COLLECT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            COLLECT: begin
                if (last_in_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = COLLECT;
                end
            end
            DRAIN: begin
                if (final_pop_s || fifo_empty_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy_s      = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s      = 1'b0;
                out_valid_s = 1'b0;
            end
            COLLECT, DRAIN: begin
                busy_s      = 1'b1;
                out_valid_s = !fifo_empty_s;
            end
            default: begin
                busy_s      = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Layer counters and sticky overflow; all cleared when a new layer is armed.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            received_count_r <= 32'd0;
            sent_count_r     <= 32'd0;
            dropped_count_r  <= 32'd0;
            overflow_r       <= 1'b0;
        end else if (flush_s) begin
            received_count_r <= 32'd0;
            sent_count_r     <= 32'd0;
            dropped_count_r  <= 32'd0;
            overflow_r       <= 1'b0;
        end else begin
            if (accept_s) begin
                received_count_r <= received_count_r + 32'd1;
            end
            if (pop_s) begin
                sent_count_r <= sent_count_r + 32'd1;
            end
            if (drop_s) begin
                dropped_count_r <= dropped_count_r + 32'd1;
                overflow_r      <= 1'b1;
            end
        end
    end

    assign out_valid      = out_valid_s;
    assign out_data       = head_s.data;
    assign out_x          = head_s.x;
    assign out_y          = head_s.y;
    assign out_ch         = head_s.ch;
    assign busy           = busy_s;
    assign done           = final_pop_s;
    assign overflow       = overflow_r;
    assign received_count = received_count_r;

endmodule

// File: tb/tb_output_stream_buffer.sv
// Directed bench: instance A (2x1x2 layer, depth 4) for streaming/backpressure/reset,
// instance B (4x1x2 layer, depth 4) for overflow and full-FIFO push+pop.
module tb_output_stream_buffer;

`ifdef OUTPUT_BUFFER_RELU_EN
    localparam logic [31:0] NEG3_EXP = 32'h0000_0000;
`else
    localparam logic [31:0] NEG3_EXP = 32'hFFFF_FFFD;
`endif

    logic        clk = 1'b0;
    logic        arst_in = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic [31:0] in_x = 32'd0;
    logic [31:0] in_y = 32'd0;
    logic [31:0] in_ch = 32'd0;
    logic        out_ready = 1'b0;

    logic        a_valid, a_busy, a_done, a_ovf;
    logic [31:0] a_data, a_x, a_y, a_ch, a_rc;
    logic        b_valid, b_busy, b_done, b_ovf;
    logic [31:0] b_data, b_x, b_y, b_ch, b_rc;

    logic        sel_b = 1'b0;
    logic        o_valid, o_busy, o_done, o_ovf;
    logic [31:0] o_data, o_x, o_y, o_ch, o_rc;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] got [16];
    int          got_n;
    int          done_cnt;
    int          done_idx;

    always #5 clk = ~clk;

    output_stream_buffer #(
        .DATA_WIDTH(32), .FIFO_DEPTH(4),
        .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(1), .OUTPUT_NB_CHANNELS(2)
    ) dut_a (
        .clk(clk), .arst_in(arst_in), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
        .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data),
        .out_x(a_x), .out_y(a_y), .out_ch(a_ch), .busy(a_busy), .done(a_done),
        .overflow(a_ovf), .received_count(a_rc)
    );

    output_stream_buffer #(
        .DATA_WIDTH(32), .FIFO_DEPTH(4),
        .FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(1), .OUTPUT_NB_CHANNELS(2)
    ) dut_b (
        .clk(clk), .arst_in(arst_in), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
        .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data),
        .out_x(b_x), .out_y(b_y), .out_ch(b_ch), .busy(b_busy), .done(b_done),
        .overflow(b_ovf), .received_count(b_rc)
    );

    always_comb begin
        if (sel_b) begin
            o_valid = b_valid; o_busy = b_busy; o_done = b_done; o_ovf = b_ovf;
            o_data = b_data; o_x = b_x; o_y = b_y; o_ch = b_ch; o_rc = b_rc;
        end else begin
            o_valid = a_valid; o_busy = a_busy; o_done = a_done; o_ovf = a_ovf;
            o_data = a_data; o_x = a_x; o_y = a_y; o_ch = a_ch; o_rc = a_rc;
        end
    end

    typedef struct packed {
        logic        start;
        logic        in_valid;
        logic        ready;
        logic [31:0] data;
        logic [31:0] x;
        logic [31:0] ch;
        logic        e_valid;
        logic [31:0] e_data;
        logic [31:0] e_x;
        logic [31:0] e_ch;
        logic        e_done;
        logic        e_busy;
        logic        e_ovf;
        logic [31:0] e_rc;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_in = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
        in_x = 32'd0; in_y = 32'd0; in_ch = 32'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arst_in = 1'b0;
    endtask

    task automatic start_layer();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_px(input logic [31:0] d, input logic [31:0] x, input logic [31:0] ch);
        in_valid = 1'b1; in_data = d; in_x = x; in_y = 32'd0; in_ch = ch;
        tick();
        in_valid = 1'b0;
    endtask

    // Hold out_ready high for a fixed number of cycles, logging every handshake and done pulse.
    task automatic drain(input int cycles);
        got_n = 0; done_cnt = 0; done_idx = -1;
        out_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (o_done) begin
                done_cnt++;
                done_idx = got_n;
            end
            if (o_valid && got_n < 16) begin
                got[got_n] = o_data;
                got_n++;
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic stream vectors: x = i%2, ch = i/2, out_ready held high.
        vecs[0] = '{1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'd5, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd1, 32'd0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'd7, 32'd0, 32'd1, 1'b1, NEG3_EXP, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 32'd2};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'd9, 32'd1, 32'd1, 1'b1, 32'd7, 32'd0, 32'd1, 1'b0, 1'b1, 1'b0, 32'd3};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 1'b1, 32'd9, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0, 32'd4};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd4};

        // Reset state.
        sel_b = 1'b0;
        do_reset();
        @(negedge clk);
        check("rst_valid", o_valid, 32'd0);
        check("rst_data", o_data, 32'd0);
        check("rst_x", o_x, 32'd0);
        check("rst_y", o_y, 32'd0);
        check("rst_ch", o_ch, 32'd0);
        check("rst_busy", o_busy, 32'd0);
        check("rst_done", o_done, 32'd0);
        check("rst_ovf", o_ovf, 32'd0);
        check("rst_rc", o_rc, 32'd0);
        tick();

        // Basic stream.
        for (int i = 0; i < 7; i++) begin
            start = vecs[i].start; in_valid = vecs[i].in_valid; in_data = vecs[i].data;
            in_x = vecs[i].x; in_y = 32'd0; in_ch = vecs[i].ch; out_ready = vecs[i].ready;
            @(negedge clk);
            check($sformatf("tbl%0d_valid", i), o_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                check($sformatf("tbl%0d_data", i), o_data, vecs[i].e_data);
                check($sformatf("tbl%0d_x", i), o_x, vecs[i].e_x);
                check($sformatf("tbl%0d_ch", i), o_ch, vecs[i].e_ch);
            end
            check($sformatf("tbl%0d_done", i), o_done, vecs[i].e_done);
            check($sformatf("tbl%0d_busy", i), o_busy, vecs[i].e_busy);
            check($sformatf("tbl%0d_ovf", i), o_ovf, vecs[i].e_ovf);
            check($sformatf("tbl%0d_rc", i), o_rc, vecs[i].e_rc);
            tick();
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        // Backpressure: head holds for 6 cycles; a start pulse mid-layer is ignored.
        do_reset();
        start_layer();
        push_px(32'd11, 32'd0, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            in_valid = (k < 4); in_data = 32'd11 + 32'(k);
            in_x = 32'(k % 2); in_ch = 32'(k / 2); start = (k == 4);
            @(negedge clk);
            check($sformatf("bp%0d_valid", k), o_valid, 32'd1);
            check($sformatf("bp%0d_data", k), o_data, 32'd11);
            check($sformatf("bp%0d_x", k), o_x, 32'd0);
            tick();
        end
        in_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        check("bp_rc", o_rc, 32'd4);
        check("bp_busy", o_busy, 32'd1);
        tick();
        drain(8);
        check("bp_count", 32'(got_n), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_order%0d", k), got[k], 32'd11 + 32'(k));
        end
        check("bp_done_cnt", 32'(done_cnt), 32'd1);
        check("bp_done_idx", 32'(done_idx), 32'd3);
        @(negedge clk);
        check("bp_busy_end", o_busy, 32'd0);
        tick();

        // Full FIFO with simultaneous push and pop: no overflow, occupancy stays at 4.
        sel_b = 1'b1;
        do_reset();
        start_layer();
        for (int k = 0; k < 4; k++) push_px(32'd1 + 32'(k), 32'(k), 32'd0);
        @(negedge clk);
        check("fpp_ovf_pre", o_ovf, 32'd0);
        check("fpp_rc_pre", o_rc, 32'd4);
        tick();
        in_valid = 1'b1; in_data = 32'd5; in_x = 32'd4; out_ready = 1'b1;
        @(negedge clk);
        check("fpp_head", o_data, 32'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("fpp_ovf", o_ovf, 32'd0);
        check("fpp_rc", o_rc, 32'd5);
        tick();
        drain(8);
        check("fpp_count", 32'(got_n), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fpp_order%0d", k), got[k], 32'd2 + 32'(k));
        end
        check("fpp_done_cnt", 32'(done_cnt), 32'd0);
        @(negedge clk);
        check("fpp_valid_end", o_valid, 32'd0);
        check("fpp_busy_end", o_busy, 32'd1);
        tick();

        // Overflow: 5th push dropped, overflow sticky, layer still completes with one done.
        do_reset();
        start_layer();
        for (int k = 0; k < 5; k++) push_px(32'd1 + 32'(k), 32'(k), 32'd0);
        @(negedge clk);
        check("ovf_flag", o_ovf, 32'd1);
        check("ovf_rc", o_rc, 32'd5);
        check("ovf_valid", o_valid, 32'd1);
        check("ovf_head", o_data, 32'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 32'd6 + 32'(k); in_x = 32'd5 + 32'(k); out_ready = 1'b1;
            @(negedge clk);
            check($sformatf("ovf_pp%0d_head", k), o_data, 32'd1 + 32'(k));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("ovf_sticky", o_ovf, 32'd1);
        check("ovf_rc_full", o_rc, 32'd8);
        tick();
        drain(8);
        check("ovf_count", 32'(got_n), 32'd4);
        check("ovf_order0", got[0], 32'd4);
        check("ovf_order1", got[1], 32'd6);
        check("ovf_order2", got[2], 32'd7);
        check("ovf_order3", got[3], 32'd8);
        check("ovf_done_cnt", 32'(done_cnt), 32'd1);
        check("ovf_done_idx", 32'(done_idx), 32'd3);
        @(negedge clk);
        check("ovf_busy_end", o_busy, 32'd0);
        check("ovf_sticky_end", o_ovf, 32'd1);
        tick();

        // Reset mid-layer, then a clean layer.
        sel_b = 1'b0;
        do_reset();
        start_layer();
        push_px(32'd21, 32'd0, 32'd0);
        push_px(32'd22, 32'd1, 32'd0);
        @(negedge clk);
        check("mid_valid_pre", o_valid, 32'd1);
        arst_in = 1'b1;
        #1;
        check("mid_valid", o_valid, 32'd0);
        check("mid_busy", o_busy, 32'd0);
        check("mid_done", o_done, 32'd0);
        check("mid_rc", o_rc, 32'd0);
        @(posedge clk);
        #1;
        arst_in = 1'b0;
        @(negedge clk);
        check("mid_busy_post", o_busy, 32'd0);
        check("mid_done_post", o_done, 32'd0);
        tick();
        start_layer();
        for (int k = 0; k < 4; k++) push_px(32'd31 + 32'(k), 32'(k % 2), 32'(k / 2));
        drain(8);
        check("re_count", 32'(got_n), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("re_order%0d", k), got[k], 32'd31 + 32'(k));
        end
        check("re_done_cnt", 32'(done_cnt), 32'd1);
        check("re_done_idx", 32'(done_idx), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
